// File: rtl/micro_pkg.sv
// Shared opcode and FSM state encodings for the micro core and its ALU.
// Pure definitions: no logic, no latency, no flow control.
package micro_pkg;

  localparam int unsigned INSTR_W = 8;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_LD   = 4'h2,
    OP_ST   = 4'h3,
    OP_IN   = 4'h4,
    OP_OUT  = 4'h5,
    OP_ADD  = 4'h6,
    OP_SUB  = 4'h7,
    OP_AND  = 4'h8,
    OP_XOR  = 4'h9,
    OP_JZ   = 4'hA,
    OP_JMP  = 4'hB,
    OP_HALT = 4'hC
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/micro_if.sv
// Program-memory, data-port and status bundle between the core and its environment.
// Wires only; instruction fetch is stalled by dropping run.
interface micro_if
  import micro_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic               run;
  logic [ADDR_W-1:0]  prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic [DATA_W-1:0]  in_data;
  logic [DATA_W-1:0]  out_sys;
  logic               out_valid;
  logic [DATA_W-1:0]  out_scratch;
  logic               halted;

  modport master (
    input  run, prog_data, in_data,
    output prog_addr, out_sys, out_valid, out_scratch, halted
  );

  modport slave (
    output run, prog_data, in_data,
    input  prog_addr, out_sys, out_valid, out_scratch, halted
  );
endinterface

// File: rtl/micro_alu.sv
// Combinational ADD/SUB/AND/XOR with zero and carry/borrow flags.
// Zero latency; no flow control.
module micro_alu
  import micro_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  opcode_e           op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] y_o,
  output logic              z_o,
  output logic              c_o
);

  // One extra bit carries the ADD carry-out or the SUB borrow.
  logic [DATA_W:0] wide;

  always_comb begin
    wide = '0;
    case (op_i)
      OP_ADD:  wide = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB:  wide = {1'b0, a_i} - {1'b0, b_i};
      OP_AND:  wide = {1'b0, a_i & b_i};
      OP_XOR:  wide = {1'b0, a_i ^ b_i};
      default: wide = '0;
    endcase
  end

  assign y_o = wide[DATA_W-1:0];
  assign c_o = wide[DATA_W];
  assign z_o = (wide[DATA_W-1:0] == '0);

endmodule

// File: rtl/micro_core.sv
// Two-cycle (FETCH, EXEC) accumulator core with scratch registers and an output port.
// Each instruction takes 2 cycles; run=0 stalls in FETCH, HALT freezes until reset.
module micro_core
  import micro_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int NREG   = 8
) (
  input logic      clk,
  input logic      rst,
  micro_if.master  bus
);

  localparam int RIDX_W = (NREG > 1) ? $clog2(NREG) : 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                z_q, z_d;
  logic                c_q, c_d;
  logic [DATA_W-1:0]   regs_q [NREG];
  logic [DATA_W-1:0]   regs_d [NREG];
  logic [DATA_W-1:0]   out_sys_q, out_sys_d;
  logic [DATA_W-1:0]   out_scratch_q, out_scratch_d;
  logic                out_valid_q, out_valid_d;

  opcode_e             op;
  logic [3:0]          k;
  logic [RIDX_W-1:0]   ridx;
  logic [DATA_W-1:0]   rval;
  logic [DATA_W-1:0]   alu_y;
  logic                alu_z;
  logic                alu_c;

  assign op   = opcode_e'(ir_q[7:4]);
  assign k    = ir_q[3:0];
  assign ridx = ir_q[RIDX_W-1:0];
  assign rval = regs_q[ridx];

  micro_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i (op),
    .a_i  (acc_q),
    .b_i  (rval),
    .y_o  (alu_y),
    .z_o  (alu_z),
    .c_o  (alu_c)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    acc_d         = acc_q;
    z_d           = z_q;
    c_d           = c_q;
    regs_d        = regs_q;
    out_sys_d     = out_sys_q;
    out_scratch_d = out_scratch_q;
    out_valid_d   = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (bus.run) begin
          ir_d    = bus.prog_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_q + ADDR_W'(1);
        case (op)
          OP_LDI: begin
            acc_d = DATA_W'(k);
            z_d   = (k == 4'd0);
          end
          OP_LD: begin
            acc_d = rval;
            z_d   = (rval == '0);
          end
          OP_ST: begin
            regs_d[ridx]  = acc_q;
            out_scratch_d = acc_q;
          end
          OP_IN: begin
            acc_d = bus.in_data;
            z_d   = (bus.in_data == '0);
          end
          OP_OUT: begin
            out_sys_d   = acc_q;
            out_valid_d = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            acc_d = alu_y;
            z_d   = alu_z;
            c_d   = alu_c;
          end
          OP_AND, OP_XOR: begin
            acc_d = alu_y;
            z_d   = alu_z;
          end
          OP_JZ: begin
            if (z_q) pc_d = ADDR_W'(k);
          end
          OP_JMP: pc_d = ADDR_W'(k);
          OP_HALT: begin
            pc_d    = pc_q;
            state_d = ST_HALT;
          end
          default: ;
        endcase
      end
      ST_HALT: ;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_FETCH;
      pc_q          <= '0;
      ir_q          <= '0;
      acc_q         <= '0;
      z_q           <= 1'b0;
      c_q           <= 1'b0;
      out_sys_q     <= '0;
      out_scratch_q <= '0;
      out_valid_q   <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      acc_q         <= acc_d;
      z_q           <= z_d;
      c_q           <= c_d;
      out_sys_q     <= out_sys_d;
      out_scratch_q <= out_scratch_d;
      out_valid_q   <= out_valid_d;
      regs_q        <= regs_d;
    end
  end

  assign bus.prog_addr   = pc_q;
  assign bus.out_sys     = out_sys_q;
  assign bus.out_scratch = out_scratch_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_micro_core.sv
// Directed-program bench for micro_core: arithmetic, flags, jumps, PC wrap, stall, halt and reset.
module tb_micro_core;
  import micro_pkg::*;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int NREG   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  micro_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic [7:0] prog [16];
  assign bus.prog_data = prog[bus.prog_addr];

  micro_core #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREG(NREG)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int vld_cnt  = 0;
  int v0;
  logic [7:0] exp_acc;

  always @(posedge clk) if (bus.out_valid === 1'b1) vld_cnt <= vld_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
  endtask

  task automatic reset_core();
    @(negedge clk);
    rst_n   = 1'b0;
    bus.run = 1'b0;
    #1;
    check("rst_prog_addr", bus.prog_addr, 0);
    check("rst_out_sys", bus.out_sys, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_scratch", bus.out_scratch, 0);
    check("rst_halted", bus.halted, 0);
    check("rst_acc", dut.acc_q, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.run     = 1'b0;
    bus.in_data = '0;
    clear_prog();

    // LDI 5; ST 1; LDI 3; ADD 1; OUT; HALT
    prog[0] = 8'h15; prog[1] = 8'h31; prog[2] = 8'h13;
    prog[3] = 8'h61; prog[4] = 8'h50; prog[5] = 8'hC0;
    reset_core();
    bus.run = 1'b1;
    cycles(4);
    check("t1_scratch", bus.out_scratch, 5);
    cycles(4);
    check("t1_acc", dut.acc_q, 8);
    check("t1_z", dut.z_q, 0);
    check("t1_c", dut.c_q, 0);
    v0 = vld_cnt;
    cycles(2);
    check("t1_out_sys", bus.out_sys, 8);
    check("t1_out_valid_hi", bus.out_valid, 1);
    cycles(1);
    check("t1_out_valid_lo", bus.out_valid, 0);
    cycles(5);
    check("t1_pulse_count", vld_cnt - v0, 1);
    check("t1_halted", bus.halted, 1);
    check("t1_halt_pc", bus.prog_addr, 5);

    // LDI 15; ST 0; LDI 1; loop { ADD 0; OUT; JMP 3 } until the sum wraps
    clear_prog();
    prog[0] = 8'h1F; prog[1] = 8'h30; prog[2] = 8'h11;
    prog[3] = 8'h60; prog[4] = 8'h50; prog[5] = 8'hB3;
    reset_core();
    bus.run = 1'b1;
    cycles(6);
    for (int i = 1; i <= 17; i++) begin
      exp_acc = 8'(1 + 15 * i);
      cycles(2);
      check("t2_acc", dut.acc_q, exp_acc);
      check("t2_z", dut.z_q, (exp_acc == 8'h00) ? 1 : 0);
      check("t2_c", dut.c_q, (i == 17) ? 1 : 0);
      cycles(2);
      check("t2_out_sys", bus.out_sys, exp_acc);
      cycles(2);
      check("t2_loop_pc", bus.prog_addr, 3);
    end

    // Equal operands: SUB gives zero and JZ is taken
    clear_prog();
    prog[0] = 8'h12; prog[1] = 8'h32; prog[2] = 8'h12;
    prog[3] = 8'h72; prog[4] = 8'hA9; prog[5] = 8'hC0; prog[9] = 8'hC0;
    reset_core();
    bus.run = 1'b1;
    cycles(8);
    check("t3_eq_acc", dut.acc_q, 0);
    check("t3_eq_z", dut.z_q, 1);
    check("t3_eq_c", dut.c_q, 0);
    cycles(2);
    check("t3_jz_taken_pc", bus.prog_addr, 9);

    // Unequal operands: 2-3 borrows and JZ falls through
    prog[0] = 8'h13;
    reset_core();
    bus.run = 1'b1;
    cycles(8);
    check("t3_ne_acc", dut.acc_q, 8'hFF);
    check("t3_ne_z", dut.z_q, 0);
    check("t3_ne_c", dut.c_q, 1);
    cycles(2);
    check("t3_jz_not_taken_pc", bus.prog_addr, 5);

    // Straight-line program: PC wraps, run=0 stalls
    clear_prog();
    prog[0] = 8'h40;
    bus.in_data = 8'hA5;
    reset_core();
    cycles(3);
    check("t4_idle_pc", bus.prog_addr, 0);
    check("t4_idle_acc", dut.acc_q, 0);
    bus.run = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      cycles(2);
      check("t4_pc_seq", bus.prog_addr, n % 16);
    end
    check("t4_in_acc", dut.acc_q, 8'hA5);
    bus.run     = 1'b0;
    bus.in_data = 8'h3C;
    cycles(3);
    check("t4_stall_pc", bus.prog_addr, 1);
    check("t4_stall_acc", dut.acc_q, 8'hA5);
    bus.run = 1'b1;
    cycles(2);
    check("t4_resume_pc", bus.prog_addr, 2);

    // HALT at address 4 holds everything until reset
    clear_prog();
    prog[0] = 8'h17; prog[1] = 8'h33; prog[2] = 8'h50;
    prog[3] = 8'h00; prog[4] = 8'hC0;
    reset_core();
    bus.run = 1'b1;
    cycles(10);
    check("t5_halted", bus.halted, 1);
    check("t5_out_sys", bus.out_sys, 7);
    check("t5_scratch", bus.out_scratch, 7);
    for (int i = 0; i < 20; i++) begin
      if (i == 10) bus.run = 1'b0;
      cycles(1);
      check("t5_halt_pc", bus.prog_addr, 4);
      check("t5_halt_hold", bus.halted, 1);
    end
    check("t5_acc_frozen", dut.acc_q, 7);
    reset_core();
    check("t5_reg_cleared", dut.regs_q[3], 0);
    bus.run = 1'b1;
    cycles(2);
    check("t5_restart_pc", bus.prog_addr, 1);
    check("t5_restart_halted", bus.halted, 0);

    // Reset lands in the EXEC cycle of OUT: no port write, no pulse
    clear_prog();
    prog[0] = 8'h19; prog[1] = 8'h50; prog[2] = 8'hC0;
    reset_core();
    bus.run = 1'b1;
    cycles(3);
    v0 = vld_cnt;
    rst_n = 1'b0;
    #1;
    check("t6_out_sys_now", bus.out_sys, 0);
    cycles(2);
    check("t6_out_sys", bus.out_sys, 0);
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_no_pulse", vld_cnt - v0, 0);
    check("t6_acc", dut.acc_q, 0);
    rst_n = 1'b1;
    cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
